// File: rtl/sips4_ram_arbiter_pkg.sv
// Shared SIPS4 RAM-arbiter types: word/address widths, requester ids and
// the read-tag carried alongside commands to steer responses.
package sips4_pkg;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_AUX = 1'b1
  } req_id_t;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  typedef struct packed {
    logic    rd_valid;
    req_id_t id;
  } tag_t;
endpackage

// File: rtl/sips4_ram_arbiter_if.sv
// One requester's command/response channel into the RAM arbiter.
interface sips4_ram_arbiter_if #(
  parameter int DATA_W = sips4_pkg::DATA_W,
  parameter int ADDR_W = sips4_pkg::ADDR_W
);
  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (output valid, we, addr, wdata, input ready, rsp_valid, rsp_rdata);
  modport slave  (input valid, we, addr, wdata, output ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/sips4_rr_arb2.sv
// Two-way arbiter: round-robin or fixed-priority grant, pointer moves only on accept.
module sips4_rr_arb2
  import sips4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       prio_mode_i,
  output logic [1:0] grant_o
);
  logic last_q, last_d;

  // last_q resets to 1 so requester 0 takes the first tie
  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (prio_mode_i == PRIO_FIXED || last_q) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  assign last_d = (|grant_o) ? grant_o[1] : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/sips4_ram_arbiter.sv
// Shares the SIPS4 data RAM between CPU and aux requesters; registers the
// winning command onto the RAM strobes and returns read data two cycles later.
module sips4_ram_arbiter
  import sips4_pkg::*;
#(
  parameter int DATA_W = sips4_pkg::DATA_W,
  parameter int ADDR_W = sips4_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prio_mode,
  sips4_ram_arbiter_if.slave       req0,
  sips4_ram_arbiter_if.slave       req1,
  output logic                     ram_wen,
  output logic [ADDR_W-1:0]        ram_waddr,
  output logic [ADDR_W-1:0]        ram_raddr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata
);
  logic [1:0]        vld, grant;
  logic              acc, sel;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  tag_t              s1_d, s1_q, s2_q;

  assign vld = {req1.valid, req0.valid};

  sips4_rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (vld),
    .prio_mode_i (prio_mode),
    .grant_o     (grant)
  );

  assign req0.ready = grant[0];
  assign req1.ready = grant[1];
  assign acc        = |grant;
  assign sel        = grant[1];

  assign we_sel    = sel ? req1.we    : req0.we;
  assign addr_sel  = sel ? req1.addr  : req0.addr;
  assign wdata_sel = sel ? req1.wdata : req0.wdata;

  always_comb begin
    s1_d.rd_valid = acc & ~we_sel;
    s1_d.id       = sel ? REQ_AUX : REQ_CPU;
  end

  // Address/data hold when idle; only the write strobe and tags are qualified
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      wen_q <= acc & we_sel;
      if (acc) begin
        addr_q  <= addr_sel;
        wdata_q <= wdata_sel;
      end
      s1_q <= s1_d;
      s2_q <= s1_q;
    end
  end

  assign ram_wen   = wen_q;
  assign ram_waddr = addr_q;
  assign ram_raddr = addr_q;
  assign ram_wdata = wdata_q;

  assign req0.rsp_valid = s2_q.rd_valid & (s2_q.id == REQ_CPU);
  assign req1.rsp_valid = s2_q.rd_valid & (s2_q.id == REQ_AUX);
  assign req0.rsp_rdata = req0.rsp_valid ? ram_rdata : '0;
  assign req1.rsp_rdata = req1.rsp_valid ? ram_rdata : '0;
endmodule

// File: tb/tb_sips4_ram_arbiter.sv
// Bench for sips4_ram_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of grants, memory and responses.
module tb_sips4_ram_arbiter;
  import sips4_pkg::*;
  localparam int DW = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic prio_mode = 1'b0;
  logic ram_wen;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  sips4_ram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) req0_if ();
  sips4_ram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) req1_if ();

  sips4_ram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prio_mode (prio_mode),
    .req0      (req0_if),
    .req1      (req1_if),
    .ram_wen   (ram_wen),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM with registered read port
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  cmd_t q0[$], q1[$];
  exp_t pend[$];
  logic [DW-1:0] ref_mem [2**AW];
  logic          m_last = 1'b1;
  logic          exp_wen = 1'b0;
  logic [AW-1:0] exp_waddr = '0;
  logic [DW-1:0] exp_wdata = '0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic we, input int addr, input int data);
    cmd_t c;
    c.we = we; c.addr = AW'(addr); c.wdata = DW'(data);
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return mk(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15));
  endfunction

  // One clock: drive at negedge, check just after, then advance the model
  task automatic step(input logic rv, input logic pm);
    logic v0, v1, ev0, ev1;
    logic [DW-1:0] ed0, ed1;
    int gid;
    cmd_t c;
    exp_t e;
    @(negedge clk);
    rst_n = rv;
    prio_mode = pm;
    v0 = (q0.size() > 0);
    v1 = (q1.size() > 0);
    c = v0 ? q0[0] : rand_cmd();
    req0_if.valid = v0; req0_if.we = c.we; req0_if.addr = c.addr; req0_if.wdata = c.wdata;
    c = v1 ? q1[0] : rand_cmd();
    req1_if.valid = v1; req1_if.we = c.we; req1_if.addr = c.addr; req1_if.wdata = c.wdata;

    if (!rv) begin
      pend.delete();
      exp_wen = 1'b0;
      m_last = 1'b1;
    end else if (exp_wen) begin
      ref_mem[exp_waddr] = exp_wdata;
    end

    gid = -1;
    if (v0 && v1) gid = (pm || m_last) ? 0 : 1;
    else if (v0)  gid = 0;
    else if (v1)  gid = 1;

    ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      if (e.id == 0) begin ev0 = 1'b1; ed0 = e.data; end
      else           begin ev1 = 1'b1; ed1 = e.data; end
    end

    #1;
    chk("req0_ready", 32'(req0_if.ready), 32'(gid == 0));
    chk("req1_ready", 32'(req1_if.ready), 32'(gid == 1));
    chk("ram_wen", 32'(ram_wen), 32'(exp_wen));
    if (exp_wen) begin
      chk("ram_waddr", 32'(ram_waddr), 32'(exp_waddr));
      chk("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
    end
    chk("rsp0_valid", 32'(req0_if.rsp_valid), 32'(ev0));
    chk("rsp0_rdata", 32'(req0_if.rsp_rdata), 32'(ed0));
    chk("rsp1_valid", 32'(req1_if.rsp_valid), 32'(ev1));
    chk("rsp1_rdata", 32'(req1_if.rsp_rdata), 32'(ed1));

    exp_wen = 1'b0;
    if (gid >= 0) begin
      if (gid == 0) c = q0.pop_front();
      else          c = q1.pop_front();
      if (rv) begin
        m_last = (gid == 1);
        if (c.we) begin
          exp_wen = 1'b1; exp_waddr = c.addr; exp_wdata = c.wdata;
        end else begin
          e.due = cyc + 2; e.id = gid; e.data = ref_mem[c.addr];
          pend.push_back(e);
        end
      end
    end
    cyc++;
  endtask

  task automatic run(input logic pm, input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || pend.size() > 0 || exp_wen) && n < budget) begin
      step(1'b1, pm);
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    req0_if.valid = 1'b0; req0_if.we = 1'b0; req0_if.addr = '0; req0_if.wdata = '0;
    req1_if.valid = 1'b0; req1_if.we = 1'b0; req1_if.addr = '0; req1_if.wdata = '0;

    // Reset state
    #2;
    chk("rst_wen", 32'(ram_wen), 32'd0);
    chk("rst_waddr", 32'(ram_waddr), 32'd0);
    chk("rst_raddr", 32'(ram_raddr), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_rsp0", 32'(req0_if.rsp_valid), 32'd0);
    chk("rst_rsp1", 32'(req1_if.rsp_valid), 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // Write then read same address from the CPU port
    q0.push_back(mk(1'b1, 3, 4'hA));
    q0.push_back(mk(1'b0, 3, 0));
    run(1'b0, 20);

    // Preload, then round-robin contention from a fresh reset
    for (int a = 0; a < 8; a++) q0.push_back(mk(1'b1, a, $urandom_range(0, 15)));
    run(1'b0, 40);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int a = 0; a < 4; a++) q0.push_back(mk(1'b0, a, 0));
    for (int a = 4; a < 8; a++) q1.push_back(mk(1'b0, a, 0));
    run(1'b0, 40);

    // Fixed priority: requester 1 waits until requester 0 goes idle
    for (int a = 0; a < 4; a++) q0.push_back(mk(1'b0, a, 0));
    for (int a = 4; a < 8; a++) q1.push_back(mk(1'b0, a, 0));
    run(1'b1, 40);

    // Aux write followed next cycle by CPU read of the same word
    q1.push_back(mk(1'b1, 5, 4'h6));
    step(1'b1, 1'b0);
    q0.push_back(mk(1'b0, 5, 0));
    run(1'b0, 20);

    // Write strobe cancelled by reset
    q0.push_back(mk(1'b1, 9, 4'hF));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // Reads in flight dropped by reset, then fresh tie goes to requester 0
    q0.push_back(mk(1'b0, 1, 0));
    q1.push_back(mk(1'b0, 2, 0));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    q0.push_back(mk(1'b0, 4, 0));
    q1.push_back(mk(1'b0, 9, 0));
    run(1'b0, 20);

    // Random traffic with mode flips and occasional resets
    for (int i = 0; i < 400; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) != 0) q0.push_back(rand_cmd());
      if (q1.size() == 0 && $urandom_range(0, 3) != 0) q1.push_back(rand_cmd());
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) == 0));
    end
    run(1'b0, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
